kim_alu_md: RTL

KIM_ALU_MD -- requirements
Module: kim_alu_md

---
 rtl/kim_alu_md.sv | 127 ++++++++++++
 1 files changed

// File: rtl/kim_alu_md.sv
// Sequential ALU: single-cycle logic/arith ops plus W-cycle radix-2 unsigned
// multiply (shift-add) and restoring divide, behind a valid/ready handshake.
module kim_alu_md #(
    parameter int ALU_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU_DATA_WIDTH-1:0] a,
    input  logic [ALU_DATA_WIDTH-1:0] b,
    input  logic [3:0]                alu_control,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALU_DATA_WIDTH-1:0] alu_result,
    output logic                      alu_zero,
    output logic                      alu_illegal
);
    localparam int W  = ALU_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;      // 00 MULLO, 01 MULHI, 10 DIVU, 11 REMU
    logic [W-1:0]    opnd_q;    // multiplicand / divisor
    logic [W-1:0]    acc_q;     // product high half / partial remainder
    logic [W-1:0]    lo_q;      // multiplier->product low half / dividend->quotient
    logic [W-1:0]    result_q;
    logic            zero_q, illegal_q;

    logic [W-1:0]    acc_d, lo_d, md_res, imm_res;
    logic [W:0]      msum, rshift, rtrial;
    logic            imm_ill, is_md;

    assign is_md = (alu_control[3:2] == 2'b10);

    always_comb begin
        imm_res = '0;
        imm_ill = 1'b0;
        case (alu_control)
            4'b0000: imm_res = a & b;
            4'b0001: imm_res = a | b;
            4'b0010: imm_res = a + b;
            4'b0110: imm_res = a - b;
            4'b0111: imm_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: imm_res = ~(a | b);
            default: imm_ill = 1'b1;
        endcase
    end

    // One iteration of either shift-add multiply or restoring divide.
    always_comb begin
        msum   = '0;
        rshift = '0;
        rtrial = '0;
        acc_d  = acc_q;
        lo_d   = lo_q;
        if (!op_q[1]) begin
            msum = lo_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
            {acc_d, lo_d} = {msum, lo_q[W-1:1]};
        end else begin
            rshift = {acc_q, lo_q[W-1]};
            rtrial = rshift - {1'b0, opnd_q};
            if (!rtrial[W]) begin
                acc_d = rtrial[W-1:0];
                lo_d  = {lo_q[W-2:0], 1'b1};
            end else begin
                acc_d = rshift[W-1:0];
                lo_d  = {lo_q[W-2:0], 1'b0};
            end
        end
        md_res = op_q[0] ? acc_d : lo_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q   <= alu_control[1:0];
                    opnd_q <= b;
                    if (is_md) begin
                        acc_q   <= '0;
                        lo_q    <= a;
                        cnt_q   <= CW'(W);
                        state_q <= BUSY;
                    end else begin
                        result_q  <= imm_res;
                        zero_q    <= (imm_res == '0);
                        illegal_q <= imm_ill;
                        state_q   <= DONE;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        result_q  <= md_res;
                        zero_q    <= (md_res == '0);
                        illegal_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign alu_result  = result_q;
    assign alu_zero    = zero_q;
    assign alu_illegal = illegal_q;
endmodule
